serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, operands a/b/cin present.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 The block SHALL have port a, input, WIDTH, augend.
REQ-007 The block SHALL have port b, input, WIDTH, addend.
REQ-008 The block SHALL have port cin, input, 1, carry in.
REQ-009 The block SHALL have port out_valid, output, 1, sum/cout valid.
REQ-010 The block SHALL have port out_ready, input, 1, consumer takes result.
REQ-011 The block SHALL have port sum, output, WIDTH, a+b+cin modulo 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1, carry out of bit WIDTH-1.
REQ-013 The block SHALL have port busy, output, 1, high while in RUN.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1, out_valid 0 and busy 0.
REQ-016 An accept SHALL occur on a clk edge where in_valid=1 and in_ready=1; the block SHALL then latch a and b into shift registers, load the carry flop with cin, clear the bit counter and enter RUN.
REQ-017 In RUN, each cycle SHALL add LSB of the a shift register, LSB of the b shift register and the carry flop using one full-adder cell.
REQ-018 In RUN, the sum bit SHALL shift into the sum register MSB-first, the a and b registers SHALL shift right, the carry flop SHALL update and the counter SHALL increment.
REQ-019 in_ready SHALL be 0 in RUN and in DONE; in_valid SHALL be ignored outside IDLE.
REQ-020 After exactly WIDTH RUN cycles the block SHALL enter DONE, so out_valid rises WIDTH cycles after the accept edge.
REQ-021 In DONE, out_valid SHALL be 1 and sum/cout SHALL hold stable until an edge with out_ready=1, after which the block SHALL return to IDLE.
REQ-022 in_ready SHALL rise in the cycle after the result handoff; no overlap of accept and handoff is allowed.
REQ-023 sum and cout SHALL retain the last result while in IDLE until the next accept.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap before the RUN-to-DONE transition.

Reset
REQ-025 While rst_n=0 at an edge, the FSM SHALL go to IDLE and sum, cout, out_valid, busy, the carry flop, the counter and the shift registers SHALL be cleared to 0.
REQ-026 in_ready SHALL read 1 after reset.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation with no partial result presented.

Configuration
REQ-028 The macro SERIAL_ADDER_OVF_EN SHALL enable the output port ovf (1 bit), the signed overflow flag, equal to the carry into bit WIDTH-1 XOR cout.
REQ-029 ovf SHALL be registered with sum, held in DONE, and cleared by reset.
REQ-030 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Package serial_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-032 Sub-module full_adder_cell SHALL be purely combinational with ports a, b, cin, sum, cout, instantiated once.

Verification (WIDTH=8)
REQ-033 Accept a=0x3C, b=0x05, cin=0 -> out_valid 8 cycles later with sum=0x41, cout=0 (ovf=0).
REQ-034 Accept a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (wrap-around); a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-035 Accept a=0x7F, b=0x01, cin=0 with SERIAL_ADDER_OVF_EN -> sum=0x80, cout=0, ovf=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> sum/cout stable, in_ready=0 with in_valid=1 driven; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-037 Assert rst_n=0 for 1 cycle when counter=3 -> next cycle IDLE, sum=0, cout=0, out_valid=0, in_ready=1; a following accept of 0x10+0x20 yields 0x30.
REQ-038 With WIDTH=1, apply all 8 combinations of a, b, cin -> sum=a^b^cin and cout=majority(a,b,cin), each with out_valid 1 cycle after accept.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the bit-serial adder.
// Provides the default operand width and the controller state type.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: single-bit combinational full adder.
// Ports: a, b, cin - operand bits and carry in
//        sum, cout - sum bit and carry out
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder producing a+b+cin, one bit per clock.
// Ports: clk, rst_n (sync, active-low)
//        in_valid/in_ready handshake with operands a, b, cin
//        out_valid/out_ready handshake with results sum, cout
//        busy - high while bits are being added
// Optional: define SERIAL_ADDER_OVF_EN to add output ovf (signed overflow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last;

    full_adder_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    assign last      = cnt == CW'(WIDTH - 1);
    assign in_ready  = state == IDLE;
    assign busy      = state == RUN;
    assign out_valid = state == DONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sr  <= a;
                    b_sr  <= b;
                    carry <= cin;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    // New bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
                    sum   <= WIDTH'({fa_sum, sum} >> 1);
                    if (last) begin
                        cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry holds the carry into the top bit on the final step
                        ovf   <= carry ^ fa_cout;
`endif
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized scoreboard bench for serial_adder (WIDTH=8 and WIDTH=1).
module tb_serial_adder;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        int          acc;
    } exp_t;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       in_valid = 0, cin = 0, out_ready = 0;
    logic [7:0] a = 0, b = 0;
    logic       in_ready, out_valid, cout, busy;
    logic [7:0] sum;
    logic       in_valid1 = 0, a1 = 0, b1 = 0, cin1 = 0, out_ready1 = 1;
    logic       in_ready1, out_valid1, sum1, cout1, busy1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf, ovf1;
`endif

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    bit   hold = 1;
    exp_t q8[$];
    exp_t q1[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf),
`endif
        .busy(busy)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf1),
`endif
        .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (!hold) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic exp_t model(int w, int unsigned x, int unsigned y, int unsigned c, int acc);
        exp_t   e;
        longint half = longint'(1) << (w - 1);
        longint t = longint'(x) + longint'(y) + longint'(c);
        longint sx = (longint'(x) >= half) ? longint'(x) - 2 * half : longint'(x);
        longint sy = (longint'(y) >= half) ? longint'(y) - 2 * half : longint'(y);
        longint st = sx + sy + longint'(c);
        e.s   = 32'(t % (2 * half));
        e.c   = t >= 2 * half;
        e.v   = (st >= half) || (st < -half);
        e.acc = acc;
        return e;
    endfunction

    task automatic send8(logic [7:0] x, logic [7:0] y, logic c);
        int n = 0;
        @(posedge clk);
        #1;
        a = x; b = y; cin = c; in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("w8_accept_timeout", 0, 1);
        else q8.push_back(model(8, x, y, c, cyc + 1));
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic send1(logic x, logic y, logic c);
        int n = 0;
        @(posedge clk);
        #1;
        a1 = x; b1 = y; cin1 = c; in_valid1 = 1;
        @(negedge clk);
        while (!in_ready1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready1) chk("w1_accept_timeout", 0, 1);
        else q1.push_back(model(1, x, y, c, cyc + 1));
        @(posedge clk);
        #1;
        in_valid1 = 0;
    endtask

    task automatic drain8();
        for (int i = 0; i < 400 && q8.size() > 0; i++) @(negedge clk);
        if (q8.size() > 0) begin
            chk("w8_drain_timeout", q8.size(), 0);
            q8.delete();
        end
    endtask

    task automatic drain1();
        for (int i = 0; i < 100 && q1.size() > 0; i++) @(negedge clk);
        if (q1.size() > 0) begin
            chk("w1_drain_timeout", q1.size(), 0);
            q1.delete();
        end
    endtask

    logic       prev_ov = 0;
    int         rise = 0;
    logic [8:0] held = 0;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !prev_ov) begin
            rise = cyc;
            held = {cout, sum};
        end else if (out_valid) chk("w8_hold_stable", {cout, sum}, held);
        if (out_valid && out_ready && rst_n) begin
            if (q8.size() == 0) chk("w8_unexpected_result", 1, 0);
            else begin
                e = q8.pop_front();
                chk("w8_sum", sum, e.s);
                chk("w8_cout", cout, e.c);
`ifdef SERIAL_ADDER_OVF_EN
                chk("w8_ovf", ovf, e.v);
`endif
                chk("w8_latency", rise - e.acc, 8);
            end
        end
        prev_ov = out_valid;
    end

    logic prev_ov1 = 0;
    int   rise1 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid1 && !prev_ov1) rise1 = cyc;
        if (out_valid1 && out_ready1 && rst_n) begin
            if (q1.size() == 0) chk("w1_unexpected_result", 1, 0);
            else begin
                e = q1.pop_front();
                chk("w1_sum", sum1, e.s);
                chk("w1_cout", cout1, e.c);
`ifdef SERIAL_ADDER_OVF_EN
                chk("w1_ovf", ovf1, e.v);
`endif
                chk("w1_latency", rise1 - e.acc, 1);
            end
        end
        prev_ov1 = out_valid1;
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        out_ready = 1;
        send8(8'h3C, 8'h05, 1'b0);
        send8(8'hFF, 8'h01, 1'b0);
        send8(8'hFF, 8'hFF, 1'b1);
        send8(8'h7F, 8'h01, 1'b0);
        drain8();

        out_ready = 0;
        send8(8'h3C, 8'h05, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach_done", out_valid, 1);
        @(posedge clk);
        #1;
        in_valid = 1; a = 8'hAA; b = 8'h55;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        out_ready = 0;
        @(negedge clk);
        chk("handoff_in_ready", in_ready, 1);
        chk("handoff_out_valid", out_valid, 0);
        drain8();

        out_ready = 1;
        send8(8'h11, 8'h22, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        q8.delete();
        @(negedge clk);
        chk("midrun_busy", busy, 1);
        @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        send8(8'h10, 8'h20, 1'b0);
        drain8();

        hold = 0;
        repeat (40) send8(8'($urandom), 8'($urandom), 1'($urandom));
        drain8();
        hold = 1;
        out_ready = 1;

        for (int i = 0; i < 8; i++) send1(1'(i >> 2), 1'(i >> 1), 1'(i));
        drain1();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
